// File: rtl/ol_health_tester_pkg.sv
// Shared constants for the online entropy health tester: register map,
// identification words, default cutoffs and the APT state encoding.
package ol_tester_pkg;

  localparam logic [7:0] ADDR_NAME0        = 8'h00;
  localparam logic [7:0] ADDR_NAME1        = 8'h01;
  localparam logic [7:0] ADDR_VERSION      = 8'h02;
  localparam logic [7:0] ADDR_CTRL         = 8'h08;
  localparam logic [7:0] ADDR_STATUS       = 8'h09;
  localparam logic [7:0] ADDR_RCT_CUTOFF   = 8'h10;
  localparam logic [7:0] ADDR_APT_CUTOFF   = 8'h11;
  localparam logic [7:0] ADDR_RCT_FAIL_CNT = 8'h20;
  localparam logic [7:0] ADDR_APT_FAIL_CNT = 8'h21;
  localparam logic [7:0] ADDR_SAMPLE_CNT   = 8'h22;

  localparam logic [31:0] CORE_NAME0   = 32'h6f6c5f74;
  localparam logic [31:0] CORE_NAME1   = 32'h65737420;
  localparam logic [31:0] CORE_VERSION = 32'h302e3230;

  localparam logic [15:0] RCT_CUTOFF_DFLT = 16'd40;
  localparam logic [15:0] APT_CUTOFF_DFLT = 16'd589;

  typedef enum logic [0:0] {
    APT_IDLE = 1'b0,
    APT_RUN  = 1'b1
  } apt_state_e;

  // Failure counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    sat_inc32 = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ol_health_tester_if.sv
// 32-bit register access bus of the health tester.
interface ol_health_tester_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output cs, output we, output address, output write_data, input read_data);
  modport slave  (input cs, input we, input address, input write_data, output read_data);
endinterface

// File: rtl/ol_health_tester_apt.sv
// Adaptive Proportion Test over fixed windows; emits one-cycle registered
// failure and window-complete pulses for the top level to accumulate.
module ol_apt_test
  import ol_tester_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH = 1,
  parameter int unsigned APT_WINDOW   = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic [SYMBOL_WIDTH-1:0] sample,
  input  logic [15:0]             cutoff,
  output logic                    fail_evt,
  output logic                    window_done
);

  localparam logic [16:0] WIN_LAST = 17'(APT_WINDOW);

  apt_state_e              state_q, state_d;
  logic [SYMBOL_WIDTH-1:0] ref_q, ref_d;
  logic [16:0]             apt_cnt_q, apt_cnt_d;
  logic [16:0]             win_cnt_q, win_cnt_d;
  logic                    fired_q, fired_d;
  logic                    fail_evt_q, fail_evt_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    apt_cnt_d  = apt_cnt_q;
    win_cnt_d  = win_cnt_q;
    fired_d    = fired_q;
    fail_evt_d = 1'b0;
    done_d     = 1'b0;
    if (clear) begin
      state_d   = APT_IDLE;
      ref_d     = '0;
      apt_cnt_d = 17'd0;
      win_cnt_d = 17'd0;
      fired_d   = 1'b0;
    end else if (sample_valid) begin
      case (state_q)
        APT_IDLE: begin
          ref_d     = sample;
          apt_cnt_d = 17'd1;
          win_cnt_d = 17'd1;
          fired_d   = 1'b0;
          state_d   = APT_RUN;
        end
        APT_RUN: begin
          win_cnt_d = win_cnt_q + 17'd1;
          apt_cnt_d = (sample == ref_q) ? apt_cnt_q + 17'd1 : apt_cnt_q;
        end
        default: state_d = APT_IDLE;
      endcase
      // fired_d guards against re-firing while non-matching samples hold the count at cutoff
      if ((cutoff != 16'd0) && !fired_d && (apt_cnt_d == {1'b0, cutoff})) begin
        fail_evt_d = 1'b1;
        fired_d    = 1'b1;
      end else begin
        fail_evt_d = 1'b0;
      end
      if (win_cnt_d == WIN_LAST) begin
        done_d  = 1'b1;
        state_d = APT_IDLE;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= APT_IDLE;
      ref_q      <= '0;
      apt_cnt_q  <= 17'd0;
      win_cnt_q  <= 17'd0;
      fired_q    <= 1'b0;
      fail_evt_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      apt_cnt_q  <= apt_cnt_d;
      win_cnt_q  <= win_cnt_d;
      fired_q    <= fired_d;
      fail_evt_q <= fail_evt_d;
      done_q     <= done_d;
    end
  end

  assign fail_evt    = fail_evt_q;
  assign window_done = done_q;

endmodule

// File: rtl/ol_health_tester.sv
// Passive entropy health monitor: Repetition Count Test, APT sub-module,
// failure/sample counters, sticky flags and the 32-bit register API.
module ol_health_tester
  import ol_tester_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH       = 1,
  parameter int unsigned APT_WINDOW         = 1024,
  parameter logic [15:0] RCT_CUTOFF_DEFAULT = RCT_CUTOFF_DFLT,
  parameter logic [15:0] APT_CUTOFF_DEFAULT = APT_CUTOFF_DFLT,
  parameter int unsigned ERROR_THRESHOLD    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ol_health_tester_if.slave       bus,
  input  logic [SYMBOL_WIDTH-1:0] entropy_data,
  input  logic                    entropy_valid,
  output logic                    ready,
  output logic                    warning,
  output logic                    error
);

  logic                    enable_q, enable_d;
  logic [15:0]             rct_cutoff_q, rct_cutoff_d;
  logic [15:0]             apt_cutoff_q, apt_cutoff_d;
  logic [31:0]             sample_cnt_q, sample_cnt_d;
  logic [31:0]             rct_fail_q, rct_fail_d;
  logic [31:0]             apt_fail_q, apt_fail_d;
  logic                    ready_q, ready_d;
  logic                    warning_q, warning_d;
  logic                    error_q, error_d;
  logic                    rct_seen_q, rct_seen_d;
  logic [SYMBOL_WIDTH-1:0] rct_last_q, rct_last_d;
  logic [15:0]             rct_cnt_q, rct_cnt_d;
  logic                    rct_evt_q, rct_evt_d;

  logic        wr_en_s, clear_s, accept_s, rct_adv_s;
  logic        apt_evt_s, apt_done_s, any_evt_s;
  logic [32:0] fail_total_s;
  logic        unused_wdata_s;

  assign wr_en_s        = bus.cs & bus.we;
  assign clear_s        = wr_en_s && (bus.address == ADDR_CTRL) && bus.write_data[1];
  assign accept_s       = enable_q && entropy_valid && !clear_s;
  assign any_evt_s      = rct_evt_q | apt_evt_s;
  assign unused_wdata_s = ^bus.write_data[31:16];

  ol_apt_test #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH),
    .APT_WINDOW   (APT_WINDOW)
  ) u_apt (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear_s),
    .sample_valid (accept_s),
    .sample       (entropy_data),
    .cutoff       (apt_cutoff_q),
    .fail_evt     (apt_evt_s),
    .window_done  (apt_done_s)
  );

  always_comb begin
    enable_d     = (wr_en_s && bus.address == ADDR_CTRL) ? bus.write_data[0] : enable_q;
    rct_cutoff_d = (wr_en_s && bus.address == ADDR_RCT_CUTOFF) ? bus.write_data[15:0] : rct_cutoff_q;
    apt_cutoff_d = (wr_en_s && bus.address == ADDR_APT_CUTOFF) ? bus.write_data[15:0] : apt_cutoff_q;
    sample_cnt_d = sample_cnt_q;
    rct_fail_d   = rct_fail_q;
    apt_fail_d   = apt_fail_q;
    ready_d      = ready_q;
    warning_d    = warning_q;
    error_d      = error_q;
    rct_seen_d   = rct_seen_q;
    rct_last_d   = rct_last_q;
    rct_cnt_d    = rct_cnt_q;
    rct_evt_d    = 1'b0;
    rct_adv_s    = 1'b0;
    fail_total_s = 33'd0;
    if (clear_s) begin
      sample_cnt_d = 32'd0;
      rct_fail_d   = 32'd0;
      apt_fail_d   = 32'd0;
      ready_d      = 1'b0;
      warning_d    = 1'b0;
      error_d      = 1'b0;
      rct_seen_d   = 1'b0;
      rct_last_d   = '0;
      rct_cnt_d    = 16'd0;
    end else begin
      if (accept_s) begin
        sample_cnt_d = sample_cnt_q + 32'd1;
        if (!rct_seen_q || (entropy_data != rct_last_q)) begin
          rct_seen_d = 1'b1;
          rct_last_d = entropy_data;
          rct_cnt_d  = 16'd1;
          rct_adv_s  = 1'b1;
        end else if (rct_cnt_q != 16'hFFFF) begin
          rct_cnt_d = rct_cnt_q + 16'd1;
          rct_adv_s = 1'b1;
        end else begin
          rct_adv_s = 1'b0;
        end
        // Cutoff compared against the register value before any same-cycle write
        rct_evt_d = rct_adv_s && (rct_cutoff_q != 16'd0) && (rct_cnt_d == rct_cutoff_q);
      end else begin
        rct_evt_d = 1'b0;
      end
      rct_fail_d   = rct_evt_q ? sat_inc32(rct_fail_q) : rct_fail_q;
      apt_fail_d   = apt_evt_s ? sat_inc32(apt_fail_q) : apt_fail_q;
      fail_total_s = {1'b0, rct_fail_d} + {1'b0, apt_fail_d};
      warning_d    = warning_q | any_evt_s;
      error_d      = error_q | (any_evt_s && (fail_total_s >= 33'(ERROR_THRESHOLD)));
      ready_d      = ready_q | apt_done_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q     <= 1'b0;
      rct_cutoff_q <= RCT_CUTOFF_DEFAULT;
      apt_cutoff_q <= APT_CUTOFF_DEFAULT;
      sample_cnt_q <= 32'd0;
      rct_fail_q   <= 32'd0;
      apt_fail_q   <= 32'd0;
      ready_q      <= 1'b0;
      warning_q    <= 1'b0;
      error_q      <= 1'b0;
      rct_seen_q   <= 1'b0;
      rct_last_q   <= '0;
      rct_cnt_q    <= 16'd0;
      rct_evt_q    <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      rct_cutoff_q <= rct_cutoff_d;
      apt_cutoff_q <= apt_cutoff_d;
      sample_cnt_q <= sample_cnt_d;
      rct_fail_q   <= rct_fail_d;
      apt_fail_q   <= apt_fail_d;
      ready_q      <= ready_d;
      warning_q    <= warning_d;
      error_q      <= error_d;
      rct_seen_q   <= rct_seen_d;
      rct_last_q   <= rct_last_d;
      rct_cnt_q    <= rct_cnt_d;
      rct_evt_q    <= rct_evt_d;
    end
  end

  always_comb begin
    bus.read_data = 32'd0;
    if (bus.cs && !bus.we) begin
      case (bus.address)
        ADDR_NAME0:        bus.read_data = CORE_NAME0;
        ADDR_NAME1:        bus.read_data = CORE_NAME1;
        ADDR_VERSION:      bus.read_data = CORE_VERSION;
        ADDR_CTRL:         bus.read_data = {31'd0, enable_q};
        ADDR_STATUS:       bus.read_data = {29'd0, error_q, warning_q, ready_q};
        ADDR_RCT_CUTOFF:   bus.read_data = {16'd0, rct_cutoff_q};
        ADDR_APT_CUTOFF:   bus.read_data = {16'd0, apt_cutoff_q};
        ADDR_RCT_FAIL_CNT: bus.read_data = rct_fail_q;
        ADDR_APT_FAIL_CNT: bus.read_data = apt_fail_q;
        ADDR_SAMPLE_CNT:   bus.read_data = sample_cnt_q;
        default:           bus.read_data = 32'd0;
      endcase
    end else begin
      bus.read_data = 32'd0;
    end
  end

  assign ready   = ready_q;
  assign warning = warning_q;
  assign error   = error_q;

endmodule

// File: tb/tb_ol_health_tester.sv
// Scoreboard bench for ol_health_tester: a behavioural model pushes expected
// register snapshots that are popped and compared once the DUT has settled.
module tb_ol_health_tester;
  import ol_tester_pkg::*;

  localparam int unsigned WIN = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [0:0] entropy_data = 1'b0;
  logic       entropy_valid = 1'b0;
  logic       ready, warning, error;

  ol_health_tester_if bus ();

  ol_health_tester #(
    .SYMBOL_WIDTH       (1),
    .APT_WINDOW         (WIN),
    .RCT_CUTOFF_DEFAULT (16'd40),
    .APT_CUTOFF_DEFAULT (16'd589),
    .ERROR_THRESHOLD    (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .entropy_data  (entropy_data),
    .entropy_valid (entropy_valid),
    .ready         (ready),
    .warning       (warning),
    .error         (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] samples;
    logic [31:0] rct_fail;
    logic [31:0] apt_fail;
    logic [2:0]  status;
  } snap_t;

  snap_t exp_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  logic        m_en, m_ready, m_warn, m_err, m_rct_seen, m_last, m_apt_run, m_ref, m_fired;
  logic [15:0] m_rct_cut, m_apt_cut;
  int unsigned m_samples, m_rct_fail, m_apt_fail, m_rct_cnt, m_apt_cnt, m_win;

  task automatic model_clear();
    m_samples = 0; m_rct_fail = 0; m_apt_fail = 0;
    m_ready = 1'b0; m_warn = 1'b0; m_err = 1'b0;
    m_rct_seen = 1'b0; m_last = 1'b0; m_rct_cnt = 0;
    m_apt_run = 1'b0; m_ref = 1'b0; m_apt_cnt = 0; m_win = 0; m_fired = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_en = 1'b0; m_rct_cut = 16'd40; m_apt_cut = 16'd589;
  endtask

  task automatic model_sample(input logic s);
    logic rct_ev, apt_ev;
    if (m_en) begin
      m_samples++;
      rct_ev = 1'b0;
      if (m_rct_seen && s == m_last) begin
        if (m_rct_cnt < 65535) begin
          m_rct_cnt++;
          rct_ev = (m_rct_cut != 16'd0) && (m_rct_cnt == m_rct_cut);
        end
      end else begin
        m_rct_seen = 1'b1; m_last = s; m_rct_cnt = 1;
        rct_ev = (m_rct_cut == 16'd1);
      end
      if (!m_apt_run) begin
        m_apt_run = 1'b1; m_ref = s; m_apt_cnt = 1; m_win = 1; m_fired = 1'b0;
      end else begin
        m_win++;
        if (s == m_ref) m_apt_cnt++;
      end
      apt_ev = (m_apt_cut != 16'd0) && !m_fired && (m_apt_cnt == m_apt_cut);
      if (apt_ev) m_fired = 1'b1;
      if (m_win == WIN) begin
        m_ready = 1'b1; m_apt_run = 1'b0;
      end
      if (rct_ev) m_rct_fail++;
      if (apt_ev) m_apt_fail++;
      if (rct_ev || apt_ev) begin
        m_warn = 1'b1;
        if (m_rct_fail + m_apt_fail >= 2) m_err = 1'b1;
      end
    end
  endtask

  function automatic snap_t model_snap();
    model_snap = {m_samples, m_rct_fail, m_apt_fail, {m_err, m_warn, m_ready}};
  endfunction

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = addr; bus.write_data = data;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0;
    if (addr == 8'h08) begin
      if (data[1]) model_clear();
      m_en = data[0];
    end else if (addr == 8'h10) m_rct_cut = data[15:0];
    else if (addr == 8'h11) m_apt_cut = data[15:0];
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = addr;
    #1 data = bus.read_data;
    bus.cs = 1'b0;
  endtask

  task automatic feed(input logic s);
    entropy_valid = 1'b1; entropy_data = s;
    @(posedge clk); #1;
    entropy_valid = 1'b0;
    model_sample(s);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic read_snap(output snap_t s);
    logic [31:0] v;
    rd(8'h22, v); s.samples = v;
    rd(8'h20, v); s.rct_fail = v;
    rd(8'h21, v); s.apt_fail = v;
    rd(8'h09, v); s.status = v[2:0];
  endtask

  task automatic test_reset();
    logic [7:0]  addrs [11] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h33};
    logic [31:0] exps  [11] = '{32'h6f6c5f74, 32'h65737420, 32'h302e3230, 32'd0, 32'd0, 32'd40, 32'd589,
                                32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] v;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 11; i++) begin
      rd(addrs[i], v);
      tests_run++;
      if (v !== exps[i]) begin
        tests_failed++;
        $display("FAIL reset_reg[%h]: got %h expected %h", addrs[i], v, exps[i]);
      end
    end
    bus.address = 8'h00;
    #1;
    tests_run++;
    if ({bus.read_data, ready, warning, error} !== {32'd0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h/%b%b%b expected 0/000", bus.read_data, ready, warning, error);
    end
  endtask

  task automatic test_rct();
    snap_t got, e;
    wr(8'h10, 32'd5);
    wr(8'h08, 32'd1);
    for (int i = 0; i < 5; i++) feed(1'b1);
    tests_run++;
    if (warning !== 1'b0) begin
      tests_failed++;
      $display("FAIL rct_latency_early: warning got %b expected 0", warning);
    end
    @(posedge clk); #1;
    tests_run++;
    if (warning !== 1'b1) begin
      tests_failed++;
      $display("FAIL rct_latency_late: warning got %b expected 1", warning);
    end
    exp_q.push_back(model_snap());
    read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL rct_first: got %h expected %h", got, e); end
    for (int i = 0; i < 10; i++) feed(1'b1);
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL rct_long_run: got %h expected %h", got, e); end
  endtask

  task automatic test_apt();
    snap_t got, e;
    logic [15:0] pat;
    wr(8'h08, 32'd3);
    wr(8'h11, 32'd10);
    for (int i = 0; i < 16; i++) feed(1'(i % 2));
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL apt_alternating: got %h expected %h", got, e); end
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL apt_ready: got %b expected 1", ready); end
    pat = 16'b0111_0111_0111_0111;
    for (int i = 0; i < 16; i++) feed(pat[i]);
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL apt_biased: got %h expected %h", got, e); end
  endtask

  task automatic test_error();
    snap_t got, e;
    logic [31:0] v;
    wr(8'h08, 32'd3);
    for (int i = 0; i < 11; i++) feed((i == 5) ? 1'b0 : 1'b1);
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL error_snap: got %h expected %h", got, e); end
    tests_run++;
    if (error !== 1'b1) begin tests_failed++; $display("FAIL error_port: got %b expected 1", error); end
    wr(8'h08, 32'd3);
    exp_q.push_back(model_snap());
    read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL clear_snap: got %h expected %h", got, e); end
    rd(8'h08, v);
    tests_run++;
    if (v !== 32'd1) begin tests_failed++; $display("FAIL clear_keeps_enable: got %h expected 1", v); end
  endtask

  task automatic test_back_to_back();
    snap_t got, e;
    logic [31:0] v;
    entropy_valid = 1'b1; entropy_data = 1'b1;
    wr(8'h08, 32'd3);
    entropy_valid = 1'b0;
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL clear_vs_sample: got %h expected %h", got, e); end
    feed(1'b1); feed(1'b0); feed(1'b1);
    wr(8'h08, 32'd0);
    for (int i = 0; i < 100; i++) feed(1'($urandom_range(1, 0)));
    settle();
    rd(8'h22, v);
    tests_run++;
    if (v !== 32'(m_samples)) begin tests_failed++; $display("FAIL disabled_samples: got %0d expected %0d", v, m_samples); end
  endtask

  task automatic test_cutoff_collision();
    snap_t got, e;
    wr(8'h08, 32'd3);
    wr(8'h10, 32'd3);
    feed(1'b1); feed(1'b1);
    entropy_valid = 1'b1; entropy_data = 1'b1;
    model_sample(1'b1);
    wr(8'h10, 32'd2);
    entropy_valid = 1'b0;
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL cutoff_same_cycle: got %h expected %h", got, e); end
    wr(8'h10, 32'd0);
    feed(1'b0);
    for (int i = 0; i < 6; i++) feed(1'b1);
    exp_q.push_back(model_snap());
    settle(); read_snap(got); e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL cutoff_zero: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_mid_window();
    logic [7:0]  addrs [7] = '{8'h10, 8'h11, 8'h08, 8'h09, 8'h20, 8'h21, 8'h22};
    logic [31:0] exps  [7] = '{32'd40, 32'd589, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] v;
    wr(8'h08, 32'd3);
    wr(8'h10, 32'd7);
    wr(8'h11, 32'd12);
    for (int i = 0; i < 8; i++) feed(1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      rd(addrs[i], v);
      tests_run++;
      if (v !== exps[i]) begin
        tests_failed++;
        $display("FAIL midreset_reg[%h]: got %h expected %h", addrs[i], v, exps[i]);
      end
    end
    tests_run++;
    if ({ready, warning, error} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midreset_flags: got %b%b%b expected 000", ready, warning, error);
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'h00; bus.write_data = 32'd0;
    test_reset();
    test_rct();
    test_apt();
    test_error();
    test_back_to_back();
    test_cutoff_collision();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ol_health_tester.md
# ol_health_tester

Parametrised successor of the online RNG tester top. It accepts a stream of entropy symbols and runs two continuous health tests on it: a Repetition Count Test (RCT) and an Adaptive Proportion Test (APT) over a fixed window. Results appear as sticky ready/warning/error flags and as failure and sample counters, all readable over the existing 32-bit register API. It sits between the noise source and the conditioner as a passive monitor; it never stalls the stream.

## Interface
Parameters:
- SYMBOL_WIDTH, 1: bits per entropy symbol, 1..8.
- APT_WINDOW, 1024: samples per APT window, power of two, 16..65536.
- RCT_CUTOFF_DEFAULT, 16'd40: RCT cutoff loaded at reset.
- APT_CUTOFF_DEFAULT, 16'd589: APT cutoff loaded at reset.
- ERROR_THRESHOLD, 2: total failure events (RCT+APT) that raise error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- cs  in  1  register access select.
- we  in  1  write enable, qualified by cs.
- address  in  8  register address.
- write_data  in  32  write data.
- read_data  out  32  read data.
- entropy_data  in  SYMBOL_WIDTH  sample under test.
- entropy_valid  in  1  entropy_data is valid this cycle.
- ready  out  1  at least one full APT window has completed since enable/clear.
- warning  out  1  sticky; at least one failure event.
- error  out  1  sticky; failure total >= ERROR_THRESHOLD.

## Operation
- Register map (word addresses): 0x00 NAME0 = 0x6f6c5f74, 0x01 NAME1 = 0x65737420, 0x02 VERSION = 0x302e3230 ("0.20"), 0x08 CTRL (bit0 enable RW, bit1 clear write-one self-clearing, reads 0), 0x09 STATUS (bit0 ready, bit1 warning, bit2 error), 0x10 RCT_CUTOFF[15:0] RW, 0x11 APT_CUTOFF[15:0] RW, 0x20 RCT_FAIL_CNT, 0x21 APT_FAIL_CNT, 0x22 SAMPLE_CNT. Unmapped reads return 0; unmapped writes are ignored.
- A sample is accepted only when enable=1 and entropy_valid=1. Accepted samples increment SAMPLE_CNT, which wraps at 2^32.
- RCT: the first sample after enable or clear sets last=sample and rct_cnt=1. For later samples: if sample==last, rct_cnt+1 (saturates at 0xFFFF); otherwise rct_cnt=1 and last=sample. When the new rct_cnt equals RCT_CUTOFF, one failure event fires. A run continuing past the cutoff fires no further events; a new run can fire again.
- APT states: IDLE -> (first accepted sample: ref=sample, apt_cnt=1, win_cnt=1) -> RUN. In RUN, each accepted sample does win_cnt+1 and, if sample==ref, apt_cnt+1. When apt_cnt reaches APT_CUTOFF, one failure event fires, at most once per window. When win_cnt reaches APT_WINDOW, ready is set and the state returns to IDLE, so the next sample starts a new window.
- A cutoff value of 0 disables that test's failure events; its counters keep running.
- warning is set on any failure event. error is set when RCT_FAIL_CNT+APT_FAIL_CNT >= ERROR_THRESHOLD. Failure counters saturate at 0xFFFFFFFF.
- clear resets all test state, counters and the ready/warning/error flags. It does not change enable or the cutoff registers.
- enable=0 freezes all test state; samples are ignored.

## Timing
- Reset values: read_data 0 when not selected; ready, warning and error 0; enable 0; counters 0; APT in IDLE; cutoffs at their defaults.
- read_data is combinational: the mapped value when cs=1 and we=0, otherwise 0.
- Writes take effect on the clock edge where cs=1 and we=1.
- A sample accepted at edge N updates counters and flags, visible at edge N+1. Each test adds one cycle of latency.
- If clear and an accepted sample occur in the same cycle, clear wins and the sample is discarded (SAMPLE_CNT=0).
- If RCT and APT both fail on the same sample, both counters increment and the failure total rises by 2.
- A cutoff write in the same cycle as a sample: the sample is compared against the old cutoff.
- Reset asserted mid-window restores every reset value at the next edge.

## Structure
- Package ol_tester_pkg holds the address localparams, the NAME/VERSION constants, the default cutoffs and the APT state encoding.
- The APT window logic is split into the sub-module ol_apt_test. RCT, the counters and the register API stay in the top level.

## Test plan
- Reset, then read 0x00/0x01/0x02 -> 0x6f6c5f74, 0x65737420, 0x302e3230. Read STATUS -> 0.
- Enable, SYMBOL_WIDTH=1, RCT_CUTOFF=5, feed 5 ones -> RCT_FAIL_CNT=1 and warning=1 one cycle after the 5th sample. Feed 10 more ones -> count stays 1.
- APT_WINDOW=16, APT_CUTOFF=10, feed an alternating pattern of 16 samples -> ready=1, APT_FAIL_CNT=0. Feed 16 samples containing 12 matches of ref -> APT_FAIL_CNT=1.
- ERROR_THRESHOLD=2: two RCT failures -> error=1. Then write CTRL=0x3 -> STATUS=0, counters 0, enable still 1.
- Clear coincident with a valid sample -> SAMPLE_CNT=0. With enable=0 and 100 valid samples -> SAMPLE_CNT unchanged.
- Assert reset_n=0 mid-window after 8 samples -> cutoffs back to 40/589, all flags and counters 0.
